ysyx_23060240_csr_seq: RTL and testbench
========================================

YSYX_23060240_CSR_SEQ -- requirements
Module: ysyx_23060240_csr_seq

Interface
REQ-001 Parameter ECALL_CAUSE, default 32'h0000000b: value written to mcause on ECALL.
REQ-002 Parameter MTVEC_ALIGN_MASK, default 32'hFFFFFFFC: mask applied to mtvec to form the trap target.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  core presents a CSR, ECALL or MRET operation.
REQ-006 req_ready  out  1  sequencer accepts a request; high only in IDLE.
REQ-007 req_op  in  3  0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET; 5..7 treated as illegal.
REQ-008 req_csr_addr  in  12  target CSR for ops 0..2.
REQ-009 req_wdata  in  32  rs1 operand for ops 0..2.
REQ-010 req_pc  in  32  PC of the requesting instruction.
REQ-011 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  out  32  old CSR value for rd; 0 for ECALL, MRET and illegal.
REQ-013 resp_redirect  out  1  qualifies resp_target; set for ECALL and MRET only.
REQ-014 resp_target  out  32  next PC on redirect.
REQ-015 resp_illegal  out  1  illegal op or unimplemented CSR address.
REQ-016 r_csr_en / r_csr_addr  out  1 / 12  read port to CSR file; r_csr_data in 32, combinational, sampled the same cycle.
REQ-017 w_csr_en / w_csr_addr / w_csr_data  out  1 / 12 / 32  write port to CSR file; strobe is one cycle.

Function
REQ-018 Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; any other address is illegal.
REQ-019 Accept when req_valid & req_ready; latch op, addr, wdata and pc; req_ready drops the next cycle.
REQ-020 States: IDLE, RD, WR, EPC_WR, CAUSE_WR, STAT_RD, STAT_WR, TVEC_RD, EPC_RD, RESP.
REQ-021 CSRRx: IDLE->RD (read, latch old value) -> WR -> RESP; resp_valid 3 cycles after acceptance.
REQ-022 CSR new value: RW=wdata, RS=old|wdata, RC=old&~wdata; RS/RC with wdata==0 skip WR (RD->RESP, latency 2, no w_csr_en).
REQ-023 Illegal address detected in RD, or illegal op detected in IDLE: go to RESP, no write, resp_illegal=1, resp_rdata=0.
REQ-024 ECALL: EPC_WR (mepc<=pc) -> CAUSE_WR (mcause<=ECALL_CAUSE) -> STAT_RD -> STAT_WR -> TVEC_RD -> RESP; resp_valid 6 cycles after acceptance.
REQ-025 ECALL mstatus update: MPIE[7]<=MIE[3], MIE<=0, MPP[12:11]<=2'b11, all other bits preserved.
REQ-026 ECALL target = mtvec & MTVEC_ALIGN_MASK.
REQ-027 MRET: STAT_RD -> STAT_WR -> EPC_RD -> RESP; resp_valid 4 cycles after acceptance; target = mepc.
REQ-028 MRET mstatus update: MIE<=MPIE, MPIE<=1, MPP<=2'b11, other bits preserved.
REQ-029 r_csr_en and w_csr_en never high in the same cycle; at most one CSR access per cycle.
REQ-030 RESP lasts exactly one cycle then returns to IDLE; a new request may be accepted the following cycle.
REQ-031 resp_* outputs are 0 whenever resp_valid is 0.
REQ-032 req_* inputs are ignored outside acceptance; changes mid-sequence have no effect.

Reset
REQ-033 rst has priority over all transitions; next edge enters IDLE regardless of state.
REQ-034 Reset values: req_ready=1 after reset edge; resp_valid, resp_redirect, resp_illegal, r_csr_en, w_csr_en = 0; all data outputs and latches = 0.
REQ-035 Reset mid-sequence abandons the operation; CSR writes already strobed remain, no further writes or response issued.

Structure
REQ-036 Shared package holds op encodings, state enum, CSR address constants and mstatus bit positions.
REQ-037 One sub-module ysyx_23060240_csr_alu: combinational RW/RS/RC value and trap/mret mstatus transforms.

Verification
REQ-038 CSRRW 0x305, wdata 0x80000100, mtvec=0 -> resp_valid at +3, rdata 0, one write 0x305<=0x80000100.
REQ-039 CSRRS 0x300, wdata 0, mstatus 0x1808 -> resp_valid at +2, rdata 0x1808, no w_csr_en.
REQ-040 ECALL pc 0x80000040, mtvec 0x80000103, mstatus 0x1808 -> writes mepc 0x80000040, mcause 0xb, mstatus 0x1880; resp at +6, redirect, target 0x80000100.
REQ-041 MRET, mstatus 0x1880, mepc 0x80000044 -> mstatus write 0x1888; resp at +4, redirect, target 0x80000044.
REQ-042 CSRRW 0x7C0 -> resp at +2, resp_illegal 1, rdata 0, no write; op 6 -> resp at +1, illegal.
REQ-043 rst asserted in STAT_RD of ECALL -> IDLE next edge, no resp_valid, no mstatus write, req_ready 1.

Source files
------------

// File: rtl/ysyx_23060240_csr_seq_pkg.sv
// Shared encodings for the CSR/trap sequencer: opcodes, FSM states,
// implemented CSR addresses and mstatus field positions.
package ysyx_23060240_csr_seq_pkg;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_EPC_WR,
    S_CAUSE_WR,
    S_STAT_RD,
    S_STAT_WR,
    S_TVEC_RD,
    S_EPC_RD,
    S_RESP
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic csr_implemented(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Combinational CSR value computation: CSRRW/RS/RC result plus the mstatus
// transforms applied on trap entry (ECALL) and trap return (MRET).
module ysyx_23060240_csr_alu
  import ysyx_23060240_csr_seq_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] csr_new_o,
  output logic [31:0] trap_mstatus_o,
  output logic [31:0] mret_mstatus_o
);

  always_comb begin
    case (op_i)
      OP_CSRRS: csr_new_o = old_i | wdata_i;
      OP_CSRRC: csr_new_o = old_i & ~wdata_i;
      default:  csr_new_o = wdata_i;
    endcase

    trap_mstatus_o                                = old_i;
    trap_mstatus_o[MSTATUS_MPIE]                  = old_i[MSTATUS_MIE];
    trap_mstatus_o[MSTATUS_MIE]                   = 1'b0;
    trap_mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mret_mstatus_o                                = old_i;
    mret_mstatus_o[MSTATUS_MIE]                   = old_i[MSTATUS_MPIE];
    mret_mstatus_o[MSTATUS_MPIE]                  = 1'b1;
    mret_mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/ysyx_23060240_csr_seq.sv
// CSR / ECALL / MRET sequencer: serialises each operation into single-access
// cycles against an external CSR file and returns a one-cycle response.
module ysyx_23060240_csr_seq
  import ysyx_23060240_csr_seq_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE      = 32'h0000000b,
  parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFFFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_target,
  output logic        resp_illegal,
  output logic        r_csr_en,
  output logic [11:0] r_csr_addr,
  input  logic [31:0] r_csr_data,
  output logic        w_csr_en,
  output logic [11:0] w_csr_addr,
  output logic [31:0] w_csr_data
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, pc_q, pc_d, old_q, old_d, target_q, target_d;
  logic        illegal_q, illegal_d;
  logic        addr_ok, is_csr_op;
  logic [31:0] csr_new, trap_mstatus, mret_mstatus;

  assign addr_ok   = csr_implemented(addr_q);
  assign is_csr_op = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);

  ysyx_23060240_csr_alu u_alu (
    .op_i           (op_q),
    .old_i          (old_q),
    .wdata_i        (wdata_q),
    .csr_new_o      (csr_new),
    .trap_mstatus_o (trap_mstatus),
    .mret_mstatus_o (mret_mstatus)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        case (req_op)
          OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_RD;
          OP_ECALL:                     state_d = S_EPC_WR;
          OP_MRET:                      state_d = S_STAT_RD;
          default:                      state_d = S_RESP;
        endcase
      end
      // RS/RC with a zero mask must not write, so they bypass WR entirely.
      S_RD:       state_d = (!addr_ok || (op_q != OP_CSRRW && wdata_q == '0)) ? S_RESP : S_WR;
      S_WR:       state_d = S_RESP;
      S_EPC_WR:   state_d = S_CAUSE_WR;
      S_CAUSE_WR: state_d = S_STAT_RD;
      S_STAT_RD:  state_d = S_STAT_WR;
      S_STAT_WR:  state_d = (op_q == OP_ECALL) ? S_TVEC_RD : S_EPC_RD;
      S_TVEC_RD:  state_d = S_RESP;
      S_EPC_RD:   state_d = S_RESP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      old_q     <= '0;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      old_q     <= old_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    old_d     = old_q;
    target_d  = target_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d      = req_op;
        addr_d    = req_csr_addr;
        wdata_d   = req_wdata;
        pc_d      = req_pc;
        old_d     = '0;
        target_d  = '0;
        illegal_d = (req_op > OP_MRET);
      end
      S_RD: begin
        if (addr_ok) old_d = r_csr_data;
        else         illegal_d = 1'b1;
      end
      S_STAT_RD: old_d    = r_csr_data;
      S_TVEC_RD: target_d = r_csr_data & MTVEC_ALIGN_MASK;
      S_EPC_RD:  target_d = r_csr_data;
      default: ;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_redirect = 1'b0;
    resp_target   = '0;
    resp_illegal  = 1'b0;
    r_csr_en      = 1'b0;
    r_csr_addr    = '0;
    w_csr_en      = 1'b0;
    w_csr_addr    = '0;
    w_csr_data    = '0;
    case (state_q)
      S_RD: if (addr_ok) begin
        r_csr_en   = 1'b1;
        r_csr_addr = addr_q;
      end
      S_WR: begin
        w_csr_en   = 1'b1;
        w_csr_addr = addr_q;
        w_csr_data = csr_new;
      end
      S_EPC_WR: begin
        w_csr_en   = 1'b1;
        w_csr_addr = CSR_MEPC;
        w_csr_data = pc_q;
      end
      S_CAUSE_WR: begin
        w_csr_en   = 1'b1;
        w_csr_addr = CSR_MCAUSE;
        w_csr_data = ECALL_CAUSE;
      end
      S_STAT_RD: begin
        r_csr_en   = 1'b1;
        r_csr_addr = CSR_MSTATUS;
      end
      S_STAT_WR: begin
        w_csr_en   = 1'b1;
        w_csr_addr = CSR_MSTATUS;
        w_csr_data = (op_q == OP_ECALL) ? trap_mstatus : mret_mstatus;
      end
      S_TVEC_RD: begin
        r_csr_en   = 1'b1;
        r_csr_addr = CSR_MTVEC;
      end
      S_EPC_RD: begin
        r_csr_en   = 1'b1;
        r_csr_addr = CSR_MEPC;
      end
      S_RESP: begin
        resp_valid    = 1'b1;
        resp_illegal  = illegal_q;
        resp_redirect = !illegal_q && !is_csr_op;
        resp_target   = (!illegal_q && !is_csr_op) ? target_q : '0;
        resp_rdata    = (!illegal_q && is_csr_op) ? old_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060240_csr_seq.sv
// Scoreboard bench for the CSR sequencer: a behavioural model predicts each
// response and CSR write; forked monitors compare whatever the DUT emits.
module tb_ysyx_23060240_csr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_csr_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid, resp_redirect, resp_illegal;
  logic [31:0] resp_rdata, resp_target;
  logic        r_csr_en, w_csr_en;
  logic [11:0] r_csr_addr, w_csr_addr;
  logic [31:0] r_csr_data, w_csr_data;

  always #5 clk = ~clk;

  ysyx_23060240_csr_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_addr(req_csr_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_redirect(resp_redirect),
    .resp_target(resp_target), .resp_illegal(resp_illegal),
    .r_csr_en(r_csr_en), .r_csr_addr(r_csr_addr), .r_csr_data(r_csr_data),
    .w_csr_en(w_csr_en), .w_csr_addr(w_csr_addr), .w_csr_data(w_csr_data)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  logic [31:0] env_csr [4];  // CSR file the DUT actually talks to
  logic [31:0] mdl_csr [4];  // model's idea of the same registers
  int          cycle_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          ri;

  function automatic int cidx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  always_comb begin
    ri = cidx(r_csr_addr);
    r_csr_data = (ri >= 0) ? env_csr[ri[1:0]] : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    int  i;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
    i = cidx(a);
    mdl_csr[i[1:0]] = d;
  endtask

  // Reference model: derives latency, response and write list from the op rules.
  task automatic predict(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc);
    exp_t        e;
    int          i;
    logic [31:0] old, nv, ms;
    e.rdata = 0; e.redirect = 0; e.target = 0; e.illegal = 0;
    i = cidx(addr);
    if (op > 3'd4) begin
      e.illegal = 1; e.cyc = cycle_cnt + 1;
    end else if (op <= 3'd2) begin
      if (i < 0) begin
        e.illegal = 1; e.cyc = cycle_cnt + 2;
      end else begin
        old = mdl_csr[i[1:0]];
        e.rdata = old;
        if (op == 3'd0)      nv = wd;
        else if (op == 3'd1) nv = old | wd;
        else                 nv = old & ~wd;
        if (op != 3'd0 && wd == 0) e.cyc = cycle_cnt + 2;
        else begin
          e.cyc = cycle_cnt + 3;
          push_wr(addr, nv);
        end
      end
    end else if (op == 3'd3) begin
      push_wr(12'h341, pc);
      push_wr(12'h342, 32'h0000000b);
      ms = mdl_csr[0];
      push_wr(12'h300, (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800);
      e.redirect = 1; e.target = mdl_csr[1] & ~32'h3; e.cyc = cycle_cnt + 6;
    end else begin
      ms = mdl_csr[0];
      push_wr(12'h300, (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800);
      e.redirect = 1; e.target = mdl_csr[2]; e.cyc = cycle_cnt + 4;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_timeout", {31'b0, req_ready}, 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    int n = 0;
    wait_ready();
    predict(op, addr, wd, pc);
    $display("txn op=%0d addr=%h wdata=%h pc=%h", op, addr, wd, pc);
    req_valid = 1; req_op = op; req_csr_addr = addr; req_wdata = wd; req_pc = pc;
    do begin
      @(posedge clk); #1; n++;
      // junk on the request bus while busy must be ignored
      req_valid = 1'($urandom); req_op = 3'($urandom);
      req_csr_addr = 12'($urandom); req_wdata = $urandom; req_pc = $urandom;
    end while (!req_ready && n < 20);
    req_valid = 0;
    chk("resp_pending", exp_q.size(), 0);
    chk("wr_pending", wr_q.size(), 0);
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
    int i;
    i = cidx(a);
    env_csr[i[1:0]] = d;
    mdl_csr[i[1:0]] = d;
  endtask

  initial begin
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    int          r;
    logic [11:0] legal_addrs [4];
    legal_addrs[0] = 12'h300; legal_addrs[1] = 12'h305;
    legal_addrs[2] = 12'h341; legal_addrs[3] = 12'h342;
    for (int i = 0; i < 4; i++) begin
      env_csr[i] = 0;
      mdl_csr[i] = 0;
    end

    fork
      forever @(posedge clk) begin
        cycle_cnt++;
        if (w_csr_en && cidx(w_csr_addr) >= 0) env_csr[cidx(w_csr_addr)] <= w_csr_data;
      end
      forever @(negedge clk) if (!rst) begin
        exp_t e;
        wr_t  w;
        chk("rw_exclusive", {31'b0, r_csr_en & w_csr_en}, 0);
        if (resp_valid) begin
          if (exp_q.size() == 0) chk("resp_unexpected", {31'b0, resp_valid}, 0);
          else begin
            e = exp_q.pop_front();
            chk("resp_cycle", cycle_cnt, e.cyc);
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_redirect", {31'b0, resp_redirect}, {31'b0, e.redirect});
            chk("resp_target", resp_target, e.target);
            chk("resp_illegal", {31'b0, resp_illegal}, {31'b0, e.illegal});
          end
        end else begin
          chk("resp_idle_zero", resp_rdata | resp_target | {30'b0, resp_redirect, resp_illegal}, 0);
        end
        if (w_csr_en) begin
          if (wr_q.size() == 0) chk("wr_unexpected", {31'b0, w_csr_en}, 0);
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", {20'b0, w_csr_addr}, {20'b0, w.addr});
            chk("wr_data", w_csr_data, w.data);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_outputs", {28'b0, resp_valid, r_csr_en, w_csr_en, resp_illegal}, 0);
    chk("rst_data", resp_rdata | resp_target | w_csr_data | {20'b0, w_csr_addr}, 0);

    // Directed scenarios from the reference examples
    set_csr(12'h300, 32'h1808);
    set_csr(12'h305, 32'h0);
    issue(3'd0, 12'h305, 32'h80000100, 32'h80000000);
    issue(3'd1, 12'h300, 32'h0, 32'h80000004);
    set_csr(12'h305, 32'h80000103);
    issue(3'd3, 12'h000, 32'h0, 32'h80000040);
    set_csr(12'h341, 32'h80000044);
    issue(3'd4, 12'h000, 32'h0, 32'h80000048);
    issue(3'd0, 12'h7C0, 32'h12345678, 32'h8000004c);
    issue(3'd6, 12'h300, 32'hFFFFFFFF, 32'h80000050);

    // Reset while ECALL sits in STAT_RD: only mepc/mcause writes may appear.
    wait_ready();
    set_csr(12'h300, 32'h1808);
    push_wr(12'h341, 32'h80000060);
    push_wr(12'h342, 32'h0000000b);
    $display("txn op=3 (reset in STAT_RD) pc=80000060");
    req_valid = 1; req_op = 3'd3; req_pc = 32'h80000060;
    repeat (3) begin
      @(posedge clk); #1; req_valid = 0;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_ready", {31'b0, req_ready}, 1);
    chk("midrst_resp", {31'b0, resp_valid}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_wr_pending", wr_q.size(), 0);
    chk("midrst_mstatus", env_csr[0], 32'h1808);

    for (int t = 0; t < 150; t++) begin
      r = int'($urandom % 16);
      if (r < 4)       op = 3'd0;
      else if (r < 8)  op = 3'd1;
      else if (r < 11) op = 3'd2;
      else if (r < 13) op = 3'd3;
      else if (r < 15) op = 3'd4;
      else             op = 3'(5 + $urandom % 3);
      r = int'($urandom % 5);
      addr = (r < 4) ? legal_addrs[r] : 12'($urandom);
      wd = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      issue(op, addr, wd, $urandom & 32'hFFFFFFFC);
    end

    for (int i = 0; i < 4; i++) chk("final_csr", env_csr[i], mdl_csr[i]);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
